// File: rtl/alu_iter.sv
// alu_iter: iterative execute-stage ALU with a valid/ready handshake.
// Add, sub, logic, compare and unknown codes finish in one cycle. Shifts
// run serially, one bit position per cycle. One operation is in flight at a time.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   request handshake (in_ready is high only in IDLE)
//   ALUcontrol, SrcA/B    operation code and operands, sampled on accept
//   flush                 synchronous abort of the in-flight operation
//   out_valid / out_ready result handshake
//   Result, Zero          registered result and its zero flag
module alu_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUcontrol,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Zero
);

  localparam int unsigned SW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
  typedef enum logic [1:0] {SH_SLL, SH_SRL, SH_SRA} shop_t;

  state_t           state_q, state_d;
  shop_t            shop_q, shop_d, shop_in;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             out_valid_q, out_valid_d;

  logic [SW-1:0]    shamt;
  logic             is_shift;
  logic [WIDTH-1:0] alu_c;
  logic [WIDTH-1:0] shifted;

  assign shamt     = SrcB[SW-1:0];
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign Result    = result_q;
  assign Zero      = zero_q;

  // Single-cycle datapath; a shift by zero simply passes SrcA through.
  always_comb begin
    alu_c    = '0;
    is_shift = 1'b0;
    shop_in  = SH_SLL;
    case (ALUcontrol)
      4'b0000: alu_c = SrcA + SrcB;
      4'b0001: alu_c = SrcA - SrcB;
      4'b0010: alu_c = SrcA & SrcB;
      4'b0011: alu_c = SrcA | SrcB;
      4'b0100: begin is_shift = 1'b1; shop_in = SH_SLL; alu_c = SrcA; end
      4'b0101: alu_c = WIDTH'($signed(SrcA) < $signed(SrcB));
      4'b0110: alu_c = SrcA ^ SrcB;
      4'b0111: begin is_shift = 1'b1; shop_in = SH_SRL; alu_c = SrcA; end
      4'b1000: alu_c = WIDTH'(SrcA < SrcB);
      4'b1111: begin is_shift = 1'b1; shop_in = SH_SRA; alu_c = SrcA; end
      default: alu_c = '0;
    endcase
  end

  // One-position shift of the accumulator.
  always_comb begin
    shifted = acc_q;
    case (shop_q)
      SH_SLL:  shifted = {acc_q[WIDTH-2:0], 1'b0};
      SH_SRL:  shifted = {1'b0, acc_q[WIDTH-1:1]};
      SH_SRA:  shifted = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
      default: shifted = acc_q;
    endcase
  end

  // Next-state and register-update logic; flush overrides everything.
  always_comb begin
    state_d     = state_q;
    shop_d      = shop_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    zero_d      = zero_q;
    out_valid_d = 1'b0;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            if (is_shift && (shamt != '0)) begin
              acc_d   = SrcA;
              cnt_d   = shamt;
              shop_d  = shop_in;
              state_d = S_SHIFT;
            end else begin
              result_d    = alu_c;
              zero_d      = (alu_c == '0);
              out_valid_d = 1'b1;
              state_d     = S_DONE;
            end
          end
        end
        S_SHIFT: begin
          acc_d = shifted;
          cnt_d = cnt_q - SW'(1);
          if (cnt_q == SW'(1)) begin
            result_d    = shifted;
            zero_d      = (shifted == '0);
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state_d = S_IDLE;
          else           out_valid_d = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      shop_q      <= SH_SLL;
      acc_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shop_q      <= shop_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
